fbf_matrix_mac: RTL and testbench
=================================

# fbf_matrix_mac

Parametrised N×N single-precision matrix multiply-accumulate engine, the next generation of the fixed 4×4 `fbf_multiplier`. It captures two N×N matrices A and B through a strobe/ack handshake. It computes R = A·B, or A·B + C when accumulate is compiled in, by sequencing one floating-point multiplier core and one floating-point adder core. It holds R until the consumer acknowledges it.

## Interface
- `FLOAT_SIZE`, 32, element width; IEEE-754 single.
- `N`, 4, matrix dimension; legal range 2..8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `A`  in  N*N*FLOAT_SIZE  matrix A; element (i,j) at bits [(i*N+j+1)*FLOAT_SIZE-1 : (i*N+j)*FLOAT_SIZE]. B, C and `result` use the same packing.
- `B`  in  N*N*FLOAT_SIZE  matrix B.
- `C`  in  N*N*FLOAT_SIZE  accumulate matrix; present only with `FBF_ACCUM_EN`.
- `A_stb`, `B_stb`  in  1  operand valid strobes.
- `A_ack`, `B_ack`  out  1  one-cycle capture acknowledge.
- `result`  out  N*N*FLOAT_SIZE  product matrix.
- `result_ready`  out  1  result valid.
- `result_ack`  in  1  consumer acknowledge.

## Operation
- The block uses one multiplier core and one adder core, each with an a/b stb/ack input handshake and a z stb/ack output handshake. Both cores share `clk` and `reset`.
- FSM states are IDLE, CAPTURE, MUL, ADD, STORE and DONE.
- IDLE: moves to CAPTURE when `A_stb` and `B_stb` are both high in the same cycle. It latches A, B (and C), and pulses `A_ack`/`B_ack` for one cycle. If only one strobe is high, nothing is latched and the FSM stays in IDLE.
- CAPTURE: clears the counters i, j, k to 0 and goes to MUL.
- MUL: presents A(i,k) and B(k,j) to the multiplier and waits for its z_stb. It acks z in the same cycle z_stb is seen and captures the product p.
- Accumulation per element (i,j):
  - Without `FBF_ACCUM_EN`: acc = p for k=0; acc = acc + p for k>0. At k=0 the FSM skips ADD.
  - With `FBF_ACCUM_EN`: acc is seeded with C(i,j), and every k passes through ADD.
- ADD: presents acc and p to the adder, waits for z_stb, acks it, and loads acc with z.
- Summation order is strictly k = 0..N-1, so results are bit-exact against a sequential reference model that uses the same cores.
- Counter wrap, in order:
  - After the last k for an element, go to STORE.
  - STORE writes acc into `result` element (i,j).
  - If j<N-1, then j++ and k=0.
  - Else if i<N-1, then i++, j=0 and k=0.
  - Else go to DONE.
- DONE: `result_ready`=1. Hold until `result_ack`=1, then go to IDLE and drop `result_ready` on the next edge. `result` keeps its last value until the next STORE or reset.
- Strobes arriving in any state other than IDLE are ignored, and no ack is given.
- `result_ack` is ignored outside DONE.
- If `result_ack` and both strobes are high in the same DONE cycle, the ack is honoured. The strobes are sampled again from IDLE on the next cycle.

## Timing
- Reset values: state=IDLE, `result`=0, `result_ready`=0, `A_ack`=`B_ack`=0, counters=0, acc=0.
- Reset is asynchronous at any time. A mid-operation reset aborts immediately, with no partial result visible afterwards.
- `A_ack`/`B_ack` are high in the cycle after the strobes are sampled, for exactly one cycle.
- Latency from capture to `result_ready` is data-dependent:
  - Exactly 1 + N*N*(1 + Σk(Tm + Ta)) + 1 cycles.
  - Tm and Ta are the multiplier and adder handshake round-trip times, including the issue cycle.
  - Ta is 0 for k=0 when accumulate is off.
- All outputs are registered.

## Configuration
- `FBF_ACCUM_EN` defined: port `C` exists and R = A·B + C. Each element costs N adds.
- `FBF_ACCUM_EN` undefined: port `C` is absent and R = A·B. Each element costs N-1 adds.

## Test plan
- N=4, A=B=all 0x3F800000 (1.0): every `result` element is 0x40800000 (4.0). `result_ready` stays high for 100 cycles with ack low, and `result` is stable throughout.
- N=4, A=identity, B=arbitrary finite values: `result`==B bit-exact. Then `result_ack` for 1 cycle: `result_ready` is 0 on the next edge.
- N=2, A=[1,2;3,4], B=[5,6;7,8]: `result` = [0x41980000, 0x41B00000; 0x422C0000, 0x42480000] (19, 22, 43, 50).
- `A_stb`=1 with `B_stb`=0 for 50 cycles: no ack and `result_ready`=0. Raising `B_stb` then starts the run.
- Reset pulse midway through a 4×4 run: `result`=0 and `result_ready`=0 immediately. A fresh run afterwards produces the correct 4.0 matrix.
- `FBF_ACCUM_EN` with A=B=C=all 1.0, N=4: every element is 0x40A00000 (5.0).

Source files
------------

// File: rtl/fbf_matrix_mac.sv
// N x N single-precision matrix multiply-accumulate engine built on one FP multiplier core and one FP adder core.
// Define FBF_ACCUM_EN to add port C and compute A*B + C instead of A*B.

module fbf_fp_unit #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_i,
    input  logic        a_stb_i,
    output logic        a_ack_o,
    input  logic [31:0] b_i,
    input  logic        b_stb_i,
    output logic        b_ack_o,
    output logic [31:0] z_o,
    output logic        z_stb_o,
    input  logic        z_ack_i
);
    logic        busy_q, busy_d, ack_q, ack_d;
    logic [31:0] z_q, z_d;

    // Round-to-nearest-even multiply; subnormals flush to zero, NaN collapses to infinity.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s, g, st, up;
        logic [47:0] m;
        logic [23:0] mant;
        logic [24:0] rnd;
        int          e;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
        if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'd0};
        m = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = 32'(x[30:23]) + 32'(y[30:23]) - 127;
        if (m[47]) begin
            mant = m[47:24]; g = m[23]; st = |m[22:0]; e = e + 1;
        end else begin
            mant = m[46:23]; g = m[22]; st = |m[21:0];
        end
        up  = g & (st | mant[0]);
        rnd = {1'b0, mant} + {24'd0, up};
        if (rnd[24]) begin rnd = rnd >> 1; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), rnd[22:0]};
    endfunction

    // Round-to-nearest-even add with guard/round/sticky alignment.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [26:0] ma, mb, sh;
        logic [27:0] sum;
        logic [24:0] rnd;
        logic        up;
        int          d, e;
        if (x[30:23] == 8'h00) return (y[30:23] == 8'h00) ? {x[31] & y[31], 31'd0} : y;
        if (y[30:23] == 8'h00) return x;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        {a, b} = (x[30:0] >= y[30:0]) ? {x, y} : {y, x};
        e  = 32'(a[30:23]);
        d  = e - 32'(b[30:23]);
        ma = {1'b1, a[22:0], 3'b000};
        mb = {1'b1, b[22:0], 3'b000};
        if (d > 26) begin
            mb = 27'd1;
        end else if (d > 0) begin
            sh = mb >> d;
            mb = sh | {26'd0, |(mb & ((27'd1 << d) - 27'd1))};
        end
        if (a[31] == b[31]) begin
            sum = {1'b0, ma} + {1'b0, mb};
            if (sum[27]) begin sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 1; end
        end else begin
            sum = {1'b0, ma - mb};
            if (sum == 28'd0) return 32'd0;
            for (int n = 0; n < 26; n++) begin
                if (!sum[26]) begin sum = sum << 1; e = e - 1; end
            end
        end
        up  = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd = {1'b0, sum[26:3]} + {24'd0, up};
        if (rnd[24]) begin rnd = rnd >> 1; e = e + 1; end
        if (e >= 255) return {a[31], 8'hFF, 23'd0};
        if (e <= 0) return {a[31], 31'd0};
        return {a[31], 8'(e), rnd[22:0]};
    endfunction

    always_comb begin
        busy_d = busy_q;
        ack_d  = 1'b0;
        z_d    = z_q;
        if (!busy_q && a_stb_i && b_stb_i) begin
            busy_d = 1'b1;
            ack_d  = 1'b1;
            z_d    = IS_ADD ? fp_add(a_i, b_i) : fp_mul(a_i, b_i);
        end else if (busy_q && z_ack_i) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            z_q    <= '0;
        end else begin
            busy_q <= busy_d;
            ack_q  <= ack_d;
            z_q    <= z_d;
        end
    end

    assign a_ack_o = ack_q;
    assign b_ack_o = ack_q;
    assign z_o     = z_q;
    assign z_stb_o = busy_q;
endmodule

module fbf_matrix_mac #(
    parameter int unsigned FLOAT_SIZE = 32,
    parameter int unsigned N          = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N*N*FLOAT_SIZE-1:0]  A,
    input  logic [N*N*FLOAT_SIZE-1:0]  B,
`ifdef FBF_ACCUM_EN
    input  logic [N*N*FLOAT_SIZE-1:0]  C,
`endif
    input  logic                       A_stb,
    input  logic                       B_stb,
    output logic                       A_ack,
    output logic                       B_ack,
    output logic [N*N*FLOAT_SIZE-1:0]  result,
    output logic                       result_ready,
    input  logic                       result_ack
);
    localparam int unsigned NE = N * N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MUL, S_ADD, S_STORE, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [FLOAT_SIZE-1:0]   a_in [NE];
    logic [FLOAT_SIZE-1:0]   b_in [NE];
    logic [FLOAT_SIZE-1:0]   a_q [NE], a_d [NE], b_q [NE], b_d [NE], res_q [NE], res_d [NE];
`ifdef FBF_ACCUM_EN
    logic [FLOAT_SIZE-1:0]   c_in [NE];
    logic [FLOAT_SIZE-1:0]   c_q [NE], c_d [NE];
`endif
    logic [CW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic [FLOAT_SIZE-1:0]   acc_q, acc_d, p_q, p_d;
    logic                    issued_q, issued_d, ack_q, ack_d, ready_q, ready_d;
    logic                    mul_stb_c, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack_c;
    logic                    add_stb_c, add_a_ack, add_b_ack, add_z_stb, add_z_ack_c;
    logic [FLOAT_SIZE-1:0]   mul_z, add_z;
    logic [IW-1:0]           idx_ik, idx_kj, idx_ij, idx_next;
    logic                    last_i, last_j, last_k;

    for (genvar e = 0; e < NE; e++) begin : g_elem
        assign a_in[e] = A[e*FLOAT_SIZE +: FLOAT_SIZE];
        assign b_in[e] = B[e*FLOAT_SIZE +: FLOAT_SIZE];
`ifdef FBF_ACCUM_EN
        assign c_in[e] = C[e*FLOAT_SIZE +: FLOAT_SIZE];
`endif
        assign result[e*FLOAT_SIZE +: FLOAT_SIZE] = res_q[e];
    end

    assign idx_ik   = IW'(i_q) * IW'(N) + IW'(k_q);
    assign idx_kj   = IW'(k_q) * IW'(N) + IW'(j_q);
    assign idx_ij   = IW'(i_q) * IW'(N) + IW'(j_q);
    assign idx_next = idx_ij + IW'(1);
    assign last_i   = (i_q == CW'(N - 1));
    assign last_j   = (j_q == CW'(N - 1));
    assign last_k   = (k_q == CW'(N - 1));

    fbf_fp_unit #(.IS_ADD(1'b0)) u_mul (
        .clk(clk), .reset(reset),
        .a_i(a_q[idx_ik]), .a_stb_i(mul_stb_c), .a_ack_o(mul_a_ack),
        .b_i(b_q[idx_kj]), .b_stb_i(mul_stb_c), .b_ack_o(mul_b_ack),
        .z_o(mul_z), .z_stb_o(mul_z_stb), .z_ack_i(mul_z_ack_c)
    );

    fbf_fp_unit #(.IS_ADD(1'b1)) u_add (
        .clk(clk), .reset(reset),
        .a_i(acc_q), .a_stb_i(add_stb_c), .a_ack_o(add_a_ack),
        .b_i(p_q), .b_stb_i(add_stb_c), .b_ack_o(add_b_ack),
        .z_o(add_z), .z_stb_o(add_z_stb), .z_ack_i(add_z_ack_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (A_stb && B_stb) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_MUL;
`ifdef FBF_ACCUM_EN
            S_MUL:     if (mul_z_stb) state_d = S_ADD;
`else
            S_MUL:     if (mul_z_stb) state_d = (k_q == '0) ? S_MUL : S_ADD;
`endif
            S_ADD:     if (add_z_stb) state_d = last_k ? S_STORE : S_MUL;
            S_STORE:   state_d = (last_i && last_j) ? S_DONE : S_MUL;
            S_DONE:    if (result_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next-state and core handshakes; the stb drops once the core has acked the operands.
    always_comb begin
        a_d = a_q; b_d = b_q; res_d = res_q;
`ifdef FBF_ACCUM_EN
        c_d = c_q;
`endif
        i_d = i_q; j_d = j_q; k_d = k_q;
        acc_d = acc_q; p_d = p_q; issued_d = issued_q;
        ack_d = 1'b0; ready_d = ready_q;
        mul_stb_c = 1'b0; mul_z_ack_c = 1'b0;
        add_stb_c = 1'b0; add_z_ack_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (A_stb && B_stb) begin
                    a_d = a_in; b_d = b_in; ack_d = 1'b1;
`ifdef FBF_ACCUM_EN
                    c_d = c_in;
`endif
                end
            end
            S_CAPTURE: begin
                i_d = '0; j_d = '0; k_d = '0; issued_d = 1'b0;
`ifdef FBF_ACCUM_EN
                acc_d = c_q[0];
`else
                acc_d = '0;
`endif
            end
            S_MUL: begin
                mul_stb_c = !issued_q;
                if (mul_a_ack && mul_b_ack) issued_d = 1'b1;
                if (mul_z_stb) begin
                    mul_z_ack_c = 1'b1;
                    issued_d    = 1'b0;
                    p_d         = mul_z;
`ifndef FBF_ACCUM_EN
                    if (k_q == '0) begin
                        acc_d = mul_z;
                        k_d   = k_q + CW'(1);
                    end
`endif
                end
            end
            S_ADD: begin
                add_stb_c = !issued_q;
                if (add_a_ack && add_b_ack) issued_d = 1'b1;
                if (add_z_stb) begin
                    add_z_ack_c = 1'b1;
                    issued_d    = 1'b0;
                    acc_d       = add_z;
                    if (!last_k) k_d = k_q + CW'(1);
                end
            end
            S_STORE: begin
                res_d[idx_ij] = acc_q;
                k_d = '0;
                if (!last_j) begin
                    j_d = j_q + CW'(1);
                end else if (!last_i) begin
                    i_d = i_q + CW'(1);
                    j_d = '0;
                end
                if (last_i && last_j) ready_d = 1'b1;
`ifdef FBF_ACCUM_EN
                else acc_d = c_q[idx_next];
`endif
            end
            S_DONE: if (result_ack) ready_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '{default: '0}; b_q <= '{default: '0}; res_q <= '{default: '0};
`ifdef FBF_ACCUM_EN
            c_q <= '{default: '0};
`endif
            i_q <= '0; j_q <= '0; k_q <= '0;
            acc_q <= '0; p_q <= '0; issued_q <= 1'b0;
            ack_q <= 1'b0; ready_q <= 1'b0;
        end else begin
            a_q <= a_d; b_q <= b_d; res_q <= res_d;
`ifdef FBF_ACCUM_EN
            c_q <= c_d;
`endif
            i_q <= i_d; j_q <= j_d; k_q <= k_d;
            acc_q <= acc_d; p_q <= p_d; issued_q <= issued_d;
            ack_q <= ack_d; ready_q <= ready_d;
        end
    end

    assign A_ack        = ack_q;
    assign B_ack        = ack_q;
    assign result_ready = ready_q;
endmodule

// File: tb/tb_fbf_matrix_mac.sv
// Bench for fbf_matrix_mac (N=4): integer-valued matrices are multiplied in plain int arithmetic and converted to IEEE bits.
module tb_fbf_matrix_mac;
    localparam int N  = 4;
    localparam int FS = 32;
    localparam int NE = N * N;
    localparam int VW = NE * FS;
`ifdef FBF_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam logic [31:0] ONES_RES = ACC ? 32'h40A00000 : 32'h40800000;

    logic          clk = 1'b0;
    logic          reset;
    logic [VW-1:0] a_bus, b_bus, result;
`ifdef FBF_ACCUM_EN
    logic [VW-1:0] c_bus;
`endif
    logic          a_stb, b_stb, a_ack, b_ack, result_ready, result_ack;
    int            checks = 0;
    int            failures = 0;
    int            ma [NE], mb [NE], mc [NE];
    logic [31:0]   w [NE];
    logic [VW-1:0] exp_r;
    logic          flag;

    always #5 clk = ~clk;

    fbf_matrix_mac #(.FLOAT_SIZE(FS), .N(N)) dut (
        .clk(clk), .reset(reset), .A(a_bus), .B(b_bus),
`ifdef FBF_ACCUM_EN
        .C(c_bus),
`endif
        .A_stb(a_stb), .B_stb(b_stb), .A_ack(a_ack), .B_ack(b_ack),
        .result(result), .result_ready(result_ready), .result_ack(result_ack)
    );

    function automatic logic [31:0] i2f(input int v);
        logic [31:0] mag;
        int          msb;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        msb = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) msb = b;
        return {1'(v < 0), 8'(127 + msb), 23'(mag << (23 - msb))};
    endfunction

    function automatic logic [VW-1:0] pack_words(input logic [31:0] ws [NE]);
        logic [VW-1:0] v = '0;
        for (int e = NE - 1; e >= 0; e--) v = (v << FS) | VW'(ws[e]);
        return v;
    endfunction

    function automatic logic [VW-1:0] pack_ints(input int m [NE]);
        logic [31:0] ws [NE];
        for (int e = 0; e < NE; e++) ws[e] = i2f(m[e]);
        return pack_words(ws);
    endfunction

    // Reference: R = A*B (+C) over integers, then converted to single precision.
    function automatic logic [VW-1:0] model_r();
        int r [NE];
        int s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = ACC ? mc[i*N+j] : 0;
                for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
                r[i*N+j] = s;
            end
        return pack_ints(r);
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_ints();
        a_bus = pack_ints(ma);
        b_bus = pack_ints(mb);
`ifdef FBF_ACCUM_EN
        c_bus = pack_ints(mc);
`endif
    endtask

    task automatic start_run(input string tag);
        a_stb = 1'b1; b_stb = 1'b1;
        @(negedge clk);
        check({tag, "_ack_hi"}, VW'({a_ack, b_ack}), VW'(2'b11));
        a_stb = 1'b0; b_stb = 1'b0;
        @(negedge clk);
        check({tag, "_ack_lo"}, VW'({a_ack, b_ack}), VW'(2'b00));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!result_ready && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_ready"}, VW'(result_ready), VW'(1));
    endtask

    task automatic ack_result(input string tag);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check({tag, "_ready_drop"}, VW'(result_ready), VW'(0));
    endtask

    initial begin
        reset = 1'b1; a_stb = 1'b0; b_stb = 1'b0; result_ack = 1'b0;
        a_bus = '0; b_bus = '0;
`ifdef FBF_ACCUM_EN
        c_bus = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_result", result, '0);
        check("rst_ready_acks", VW'({result_ready, a_ack, b_ack}), VW'(0));
        reset = 1'b0;
        @(negedge clk);

        // One strobe alone must not start anything.
        for (int e = 0; e < NE; e++) begin ma[e] = 1; mb[e] = 1; mc[e] = 1; end
        drive_ints();
        a_stb = 1'b1;
        flag = 1'b0;
        repeat (50) begin @(negedge clk); flag |= a_ack | b_ack | result_ready; end
        check("a_stb_only", VW'(flag), VW'(0));
        b_stb = 1'b1;
        @(negedge clk);
        check("ones_ack_hi", VW'({a_ack, b_ack}), VW'(2'b11));
        a_stb = 1'b0; b_stb = 1'b0;
        @(negedge clk);
        check("ones_ack_lo", VW'({a_ack, b_ack}), VW'(2'b00));
        wait_ready("ones");
        check("ones_result", result, {NE{ONES_RES}});
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!result_ready || result !== {NE{ONES_RES}}) flag = 1'b0;
        end
        check("ones_hold", VW'(flag), VW'(1));
        ack_result("ones");

        // Identity times arbitrary finite B; strobes and result_ack mid-run must be ignored.
        for (int e = 0; e < NE; e++) begin
            ma[e] = (e / N == e % N) ? 1 : 0;
            mc[e] = 0;
            w[e]  = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
        end
        drive_ints();
        b_bus = pack_words(w);
        start_run("ident");
        repeat (20) @(negedge clk);
        a_stb = 1'b1; b_stb = 1'b1; result_ack = 1'b1;
        a_bus = '0;
        flag = 1'b0;
        repeat (10) begin @(negedge clk); flag |= a_ack | b_ack | result_ready; end
        a_stb = 1'b0; b_stb = 1'b0; result_ack = 1'b0;
        check("ident_midrun_ignored", VW'(flag), VW'(0));
        wait_ready("ident");
        check("ident_result", result, pack_words(w));

        // 2x2 case embedded top-left, zero padded; ack and new strobes in the same DONE cycle.
        for (int e = 0; e < NE; e++) begin ma[e] = 0; mb[e] = 0; mc[e] = 0; end
        ma[0] = 1; ma[1] = 2; ma[4] = 3; ma[5] = 4;
        mb[0] = 5; mb[1] = 6; mb[4] = 7; mb[5] = 8;
        drive_ints();
        a_stb = 1'b1; b_stb = 1'b1; result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check("done_ack_wins", VW'({result_ready, a_ack, b_ack}), VW'(0));
        @(negedge clk);
        check("idle_recapture", VW'({a_ack, b_ack}), VW'(2'b11));
        a_stb = 1'b0; b_stb = 1'b0;
        for (int e = 0; e < NE; e++) w[e] = 32'h0;
        w[0] = 32'h41980000; w[1] = 32'h41B00000; w[4] = 32'h422C0000; w[5] = 32'h42480000;
        wait_ready("two");
        check("two_result", result, pack_words(w));
        ack_result("two");

        // Random signed integer matrices against the integer model.
        for (int t = 0; t < 4; t++) begin
            for (int e = 0; e < NE; e++) begin
                ma[e] = ($urandom_range(1, 0) == 1) ? -int'($urandom_range(8, 1)) : int'($urandom_range(8, 1));
                mb[e] = ($urandom_range(1, 0) == 1) ? -int'($urandom_range(8, 1)) : int'($urandom_range(8, 1));
                mc[e] = int'($urandom_range(16, 0)) - 8;
            end
            drive_ints();
            exp_r = model_r();
            start_run("rand");
            wait_ready("rand");
            check("rand_result", result, exp_r);
            ack_result("rand");
        end

        // Asynchronous reset in the middle of a run, then a clean rerun.
        for (int e = 0; e < NE; e++) begin ma[e] = 1; mb[e] = 1; mc[e] = 1; end
        drive_ints();
        start_run("abort");
        repeat (150) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_result", result, '0);
        check("abort_ready", VW'(result_ready), VW'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_run("rerun");
        wait_ready("rerun");
        check("rerun_result", result, {NE{ONES_RES}});
        ack_result("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
